// File: rtl/pe_seq_ctrl.sv
// Command sequencer driving one PE_Block (or a broadcast PE row): LOAD / ALU / SHIFT / NOP.
// PE-side outputs are registered from the current state and inputs, so they trail the state by one cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | cmd_ready high, waiting for a command
//   LOAD     | ld_ready high, each accepted word written at src_a+idx
//   ALU_RD   | present operand addresses and op to the PE
//   ALU_WAIT | hold operands, wait for op_done or TIMEOUT
//   ALU_WB   | write ALU result to dst via port A
//   SH_RD    | read src_b from the selected neighbour
//   SH_WR    | write neighbour word to dst via port B
//   FIN      | emit done (and err after a timeout)
module pe_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [ADDR_WIDTH-1:0] cmd_src_a,
  input  logic [ADDR_WIDTH-1:0] cmd_src_b,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [1:0]            cmd_alu_op,
  input  logic [1:0]            cmd_dir,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  pe_ram_init,
  output logic                  pe_wea,
  output logic                  pe_web,
  output logic [ADDR_WIDTH-1:0] pe_addra,
  output logic [ADDR_WIDTH-1:0] pe_addrb,
  output logic [DATA_WIDTH-1:0] pe_bram_in,
  output logic                  pe_east,
  output logic                  pe_west,
  output logic                  pe_south,
  output logic                  pe_north,
  output logic [1:0]            pe_op,
  input  logic                  pe_op_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ALU_RD, S_ALU_WAIT, S_ALU_WB, S_SH_RD, S_SH_WR, S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_a_q, src_a_d;
  logic [ADDR_WIDTH-1:0]   src_b_q, src_b_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [1:0]              alu_op_q, alu_op_d;
  logic [1:0]              dir_q, dir_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    tmo_err_q, tmo_err_d;

  logic                    ram_init_q, ram_init_d;
  logic                    wea_q, wea_d;
  logic                    web_q, web_d;
  logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
  logic [ADDR_WIDTH-1:0]   addrb_q, addrb_d;
  logic [DATA_WIDTH-1:0]   bram_in_q, bram_in_d;
  logic [3:0]              nbr_q, nbr_d;
  logic [1:0]              pe_op_q, pe_op_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [3:0]              dir_oh;

  // bit order {north, south, west, east} follows the cmd_dir encoding
  assign dir_oh = 4'b0001 << dir_q;

  always_comb begin
    state_d     = state_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_d       = dst_q;
    len_d       = len_q;
    alu_op_d    = alu_op_q;
    dir_d       = dir_q;
    tmo_d       = tmo_q;
    tmo_err_d   = tmo_err_q;
    ram_init_d  = 1'b0;
    wea_d       = 1'b0;
    web_d       = 1'b0;
    addra_d     = '0;
    addrb_d     = '0;
    bram_in_d   = '0;
    nbr_d       = '0;
    pe_op_d     = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_a_d   = cmd_src_a;
          src_b_d   = cmd_src_b;
          dst_d     = cmd_dst;
          len_d     = cmd_len;
          alu_op_d  = cmd_alu_op;
          dir_d     = cmd_dir;
          tmo_err_d = 1'b0;
          unique case (cmd_type)
            2'b00:   state_d = S_LOAD;
            2'b01:   state_d = S_ALU_RD;
            2'b10:   state_d = S_SH_RD;
            default: state_d = S_FIN;
          endcase
        end
      end
      S_LOAD: begin
        // src_a_q doubles as the LOAD write pointer; len_q counts remaining words down to 0
        if (ld_valid) begin
          ram_init_d = 1'b1;
          wea_d      = 1'b1;
          addra_d    = src_a_q;
          bram_in_d  = ld_data;
          src_a_d    = src_a_q + ADDR_WIDTH'(1);
          if (len_q == '0) state_d = S_FIN;
          else             len_d   = len_q - ADDR_WIDTH'(1);
        end
      end
      S_ALU_RD: begin
        addra_d = src_a_q;
        addrb_d = src_b_q;
        pe_op_d = alu_op_q;
        tmo_d   = TW'(TIMEOUT - 1);
        state_d = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        addra_d = src_a_q;
        addrb_d = src_b_q;
        pe_op_d = alu_op_q;
        if (pe_op_done) begin
          state_d = S_ALU_WB;
        end else if (tmo_q == '0) begin
          tmo_err_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_ALU_WB: begin
        wea_d   = 1'b1;
        addra_d = dst_q;
        pe_op_d = alu_op_q;
        state_d = S_FIN;
      end
      S_SH_RD: begin
        addrb_d = src_b_q;
        nbr_d   = dir_oh;
        state_d = S_SH_WR;
      end
      S_SH_WR: begin
        addrb_d = dst_q;
        web_d   = 1'b1;
        nbr_d   = dir_oh;
        state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        err_d   = tmo_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      alu_op_q   <= '0;
      dir_q      <= '0;
      tmo_q      <= '0;
      tmo_err_q  <= 1'b0;
      ram_init_q <= 1'b0;
      wea_q      <= 1'b0;
      web_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      bram_in_q  <= '0;
      nbr_q      <= '0;
      pe_op_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      alu_op_q   <= alu_op_d;
      dir_q      <= dir_d;
      tmo_q      <= tmo_d;
      tmo_err_q  <= tmo_err_d;
      ram_init_q <= ram_init_d;
      wea_q      <= wea_d;
      web_q      <= web_d;
      addra_q    <= addra_d;
      addrb_q    <= addrb_d;
      bram_in_q  <= bram_in_d;
      nbr_q      <= nbr_d;
      pe_op_q    <= pe_op_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign ld_ready    = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign pe_ram_init = ram_init_q;
  assign pe_wea      = wea_q;
  assign pe_web      = web_q;
  assign pe_addra    = addra_q;
  assign pe_addrb    = addrb_q;
  assign pe_bram_in  = bram_in_q;
  assign pe_east     = nbr_q[0];
  assign pe_west     = nbr_q[1];
  assign pe_south    = nbr_q[2];
  assign pe_north    = nbr_q[3];
  assign pe_op       = pe_op_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
